// File: rtl/io_uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package io_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [31:0] TXDATA_OFFSET = 32'd0;
  localparam logic [31:0] STATUS_OFFSET = 32'd4;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;
  localparam int unsigned STAT_COUNT_MSB = 5;

endpackage

// File: rtl/io_uart_tx_port_if.sv
// Processor I/O data-bus bundle seen by the UART transmitter.
interface io_uart_tx_port_if;

  logic [31:0] address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] io_memory_write;
  logic [31:0] io_memory_read;
  logic        valid_io_read;

  modport master (
    output address, MemWrite, MemRead, io_memory_write,
    input  io_memory_read, valid_io_read
  );

  modport slave (
    input  address, MemWrite, MemRead, io_memory_write,
    output io_memory_read, valid_io_read
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; push is ignored when full, pop is ignored when empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx_port.sv
// Memory-mapped UART transmitter: bus decode, status register, baud timing and frame FSM.
module io_uart_tx_port
  import io_uart_pkg::*;
#(
  parameter int unsigned INPUT_CLOCK_RATE = 33_333_333,
  parameter int unsigned BAUD_RATE        = 19_200,
  parameter logic [31:0] BASE_ADDRESS     = 32'h00007f30,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  io_uart_tx_port_if.slave  bus,
  output logic              tx_out,
  output logic              tx_busy
);

  localparam int unsigned DIV = INPUT_CLOCK_RATE / BAUD_RATE;
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  logic          wr_tx, wr_st, rd_tx, rd_st;
  logic          fifo_full, fifo_empty, pop, push_ok;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [31:0]   status_word;
  logic          unused_wdata_hi;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d, busy_d, baud_end;

  assign wr_tx   = bus.MemWrite && (bus.address == BASE_ADDRESS + TXDATA_OFFSET);
  assign wr_st   = bus.MemWrite && (bus.address == BASE_ADDRESS + STATUS_OFFSET);
  assign rd_tx   = bus.MemRead  && (bus.address == BASE_ADDRESS + TXDATA_OFFSET);
  assign rd_st   = bus.MemRead  && (bus.address == BASE_ADDRESS + STATUS_OFFSET);
  assign push_ok = wr_tx && !fifo_full;
  assign unused_wdata_hi = ^bus.io_memory_write[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .pop   (pop),
    .din   (bus.io_memory_write[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word                                = '0;
    status_word[STAT_BUSY_BIT]                 = tx_busy;
    status_word[STAT_FULL_BIT]                 = fifo_full;
    status_word[STAT_OVF_BIT]                  = overflow;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 3'(fifo_count);
  end

  // Read data is sampled from pre-edge registers, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_io_read  <= 1'b0;
      bus.io_memory_read <= '0;
      overflow           <= 1'b0;
    end else begin
      bus.valid_io_read  <= rd_tx || rd_st;
      bus.io_memory_read <= rd_st ? status_word : '0;
      if (wr_st)                      overflow <= 1'b0;
      else if (wr_tx && fifo_full)    overflow <= 1'b1;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    // Busy reflects the post-edge FIFO occupancy so it moves with the FSM and FIFO.
    busy_d = (state_d != IDLE) || push_ok || (fifo_count > CW'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_out    <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_out    <= tx_d;
      tx_busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Scoreboard bench for io_uart_tx_port: bus reads and serial frames are checked by monitors.
module tb_io_uart_tx_port;

  localparam logic [31:0] BASE = 32'h00007f30;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'd4;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_out, tx_busy;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   decode_en = 1'b1;

  logic [31:0] rd_q[$];
  frame_t      fr_q[$];

  io_uart_tx_port_if bus_if ();

  io_uart_tx_port #(
    .INPUT_CLOCK_RATE (16),
    .BAUD_RATE        (1),
    .BASE_ADDRESS     (BASE),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .tx_out  (tx_out),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic re, input logic [31:0] d);
    @(negedge clk);
    bus_if.address         = a;
    bus_if.MemWrite        = we;
    bus_if.MemRead         = re;
    bus_if.io_memory_write = d;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Read monitor: every valid cycle consumes one expected read value.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_io_read_s() === 1'b1) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: valid_io_read=1 data=0x%08h, expected no read",
                   bus_if.io_memory_read);
        end else begin
          check("read_data", bus_if.io_memory_read, rd_q.pop_front());
        end
      end
    end
  end

  function automatic logic valid_io_read_s();
    return bus_if.valid_io_read;
  endfunction

  // Serial decoder: samples each bit at its middle and checks spacing of back-to-back frames.
  initial begin
    int         s;
    int         last_start;
    logic [7:0] b;
    logic       ok;
    frame_t     f;
    last_start = -1000;
    forever begin
      @(negedge clk);
      if (decode_en && tx_out === 1'b0) begin
        s  = cyc;
        ok = 1'b1;
        repeat (7) @(negedge clk);
        if (tx_out !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (16) @(negedge clk);
        if (tx_out !== 1'b1) ok = 1'b0;
        if (fr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", b);
        end else begin
          f = fr_q.pop_front();
          check("frame", {23'h0, ok, b}, {23'h0, 1'b1, f.data});
          if (f.b2b) check("frame_gap", 32'(s - last_start), 32'd160);
        end
        last_start = s;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.address         = '0;
    bus_if.MemWrite        = 1'b0;
    bus_if.MemRead         = 1'b0;
    bus_if.io_memory_write = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_valid", bus_if.valid_io_read, 0);
    check("rst_rdata", bus_if.io_memory_read, 0);
    rst_n = 1'b1;

    rd_q.push_back(32'h0);
    drive(STA, 1'b0, 1'b1, 32'h0);
    idle();
    check("idle_line", tx_out, 1);
    repeat (3) idle();

    // Single byte 0x55 with exact bit timing
    fr_q.push_back('{8'h55, 1'b0});
    drive(TXD, 1'b1, 1'b0, 32'h55);
    idle();
    check("line_high_write_cycle", tx_out, 1);
    check("busy_after_write", tx_busy, 1);
    @(negedge clk);
    check("start_bit_begin", tx_out, 0);
    repeat (15) @(negedge clk);
    check("start_bit_end", tx_out, 0);
    @(negedge clk);
    check("data_bit0", tx_out, 1);
    repeat (143) @(negedge clk);
    check("busy_before_frame_end", tx_busy, 1);
    @(negedge clk);
    check("busy_after_frame_end", tx_busy, 0);
    check("line_idle_after_frame", tx_out, 1);
    repeat (5) idle();

    // Six back-to-back writes: 0x01 popped at once, 0x02..0x05 fill the FIFO, 0x06 overflows
    fr_q.push_back('{8'h01, 1'b0});
    for (int i = 2; i <= 5; i++) fr_q.push_back('{8'(i), 1'b1});
    for (int i = 1; i <= 6; i++) drive(TXD, 1'b1, 1'b0, 32'(i) | 32'hFFFF_FF00);
    rd_q.push_back(32'h27);
    drive(STA, 1'b0, 1'b1, 32'h0);
    rd_q.push_back(32'h27);
    drive(STA, 1'b1, 1'b1, 32'hFFFF_FFFF);
    rd_q.push_back(32'h23);
    drive(STA, 1'b0, 1'b1, 32'h0);

    // Non-matching addresses
    drive(BASE + 32'd8, 1'b0, 1'b1, 32'h0);
    idle();
    check("bad_read_no_valid", bus_if.valid_io_read, 0);
    drive(BASE - 32'd4, 1'b1, 1'b0, 32'hAA);
    rd_q.push_back(32'h23);
    drive(STA, 1'b0, 1'b1, 32'h0);
    rd_q.push_back(32'h0);
    drive(TXD, 1'b0, 1'b1, 32'h0);
    idle();

    for (int i = 0; i < 1200 && tx_busy === 1'b1; i++) @(negedge clk);
    check("drain_busy", tx_busy, 0);
    repeat (5) idle();
    check("frames_consumed", fr_q.size(), 0);
    rd_q.push_back(32'h0);
    drive(STA, 1'b0, 1'b1, 32'h0);
    idle();
    idle();
    check("reads_consumed", rd_q.size(), 0);

    // Reset in the middle of DATA (0xA5: bit1 is 0)
    decode_en = 1'b0;
    drive(TXD, 1'b1, 1'b0, 32'hA5);
    idle();
    repeat (39) @(negedge clk);
    check("data_bit1_before_reset", tx_out, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_out", tx_out, 1);
    check("async_rst_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", tx_busy, 0);
    rd_q.push_back(32'h0);
    drive(STA, 1'b0, 1'b1, 32'h0);
    idle();
    decode_en = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_line", tx_out, 1);
    check("post_rst_reads_consumed", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
